// File: rtl/dpram_bist_pkg.sv
// dpram_bist_pkg
// Shared types and helpers for the dual-port RAM self-test engine.
//  - state_t      : test sequencer states
//  - RD_LAT_MIN/MAX : supported RAM read latencies
//  - pat()        : test pattern generator (seed XOR address)
// Optional feature macro used by this slice: DPRAM_BIST_ERR_CAPTURE_EN
package dpram_bist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR1,
      RD1,
      DRN1,
      WR2,
      RD2,
      DRN2,
      DONE
   } state_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   localparam int PAT_W = 32;

   // Pattern for one address; callers truncate to their data width.
   function automatic logic [PAT_W-1:0] pat(input logic [PAT_W-1:0] seed,
                                           input logic [PAT_W-1:0] a);
      return seed ^ a;
   endfunction

endpackage

// File: rtl/dpram_bist_chk.sv
// dpram_bist_chk
// Read-data checker for the self-test engine. Every issued read is pushed
// into an RD_LAT-deep pipe of {valid, port select, expected data[, address]}
// so that the expectation lines up with the RAM data when it returns.
// Ports:
//  clk, rst      clock, synchronous active-high reset (empties the pipe)
//  issue_vld     a read is issued this cycle
//  issue_sel_b   1 = compare against dout_b, 0 = dout_a
//  issue_exp     expected data for the issued read
//  dout_a/dout_b RAM read data
//  mismatch      returning data differs from expectation (combinational)
//  mis_exp/mis_got expected and received data of the returning read
// With DPRAM_BIST_ERR_CAPTURE_EN: issue_adr in, mis_adr out.
import dpram_bist_pkg::*;

module dpram_bist_chk #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_vld,
   input  logic              issue_sel_b,
   input  logic [DATA_W-1:0] issue_exp,
   input  logic [DATA_W-1:0] dout_a,
   input  logic [DATA_W-1:0] dout_b,
   output logic              mismatch,
   output logic [DATA_W-1:0] mis_exp,
   output logic [DATA_W-1:0] mis_got
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
   ,
   input  logic [ADDR_W-1:0] issue_adr,
   output logic [ADDR_W-1:0] mis_adr
`endif
);

   logic [RD_LAT-1:0]             pipe_vld;
   logic [RD_LAT-1:0]             pipe_sel;
   logic [RD_LAT-1:0][DATA_W-1:0] pipe_exp;
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
   logic [RD_LAT-1:0][ADDR_W-1:0] pipe_adr;
`endif

   // Delay line: stage 0 captures the read issued this cycle, the last
   // stage holds the read whose data is on dout right now.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_vld <= '0;
         pipe_sel <= '0;
         pipe_exp <= '0;
      end else begin
         pipe_vld[0] <= issue_vld;
         pipe_sel[0] <= issue_sel_b;
         pipe_exp[0] <= issue_exp;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_sel[i] <= pipe_sel[i-1];
            pipe_exp[i] <= pipe_exp[i-1];
         end
      end
   end

`ifdef DPRAM_BIST_ERR_CAPTURE_EN
   // Address travels alongside the expectation only when it is reported.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_adr <= '0;
      end else begin
         pipe_adr[0] <= issue_adr;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_adr[i] <= pipe_adr[i-1];
         end
      end
   end

   assign mis_adr = pipe_adr[RD_LAT-1];
`endif

   // Compare the returning data against the port it was read from.
   always_comb begin
      mis_exp  = pipe_exp[RD_LAT-1];
      mis_got  = pipe_sel[RD_LAT-1] ? dout_b : dout_a;
      mismatch = pipe_vld[RD_LAT-1] && (mis_got != mis_exp);
   end

endmodule

// File: rtl/dpram_bist.sv
// dpram_bist
// Built-in self-test engine driving both ports of a dual-port RAM.
// Pass 1 writes pat(a) through port A and reads it back through port B;
// pass 2 writes ~pat(a) through port B and reads it back through port A.
// Ports:
//  clk, rst        clock, synchronous active-high reset
//  start           1-cycle pulse, starts a test from IDLE or DONE
//  busy            test in progress
//  done, pass      run finished / finished with zero mismatches
//  err_cnt         saturating mismatch count
//  ce, we_a, we_b  RAM chip enable and per-port write enables
//  din_a/adr_a     RAM port A write data and address
//  din_b/adr_b     RAM port B write data and address
//  dout_a/dout_b   RAM read data
// With DPRAM_BIST_ERR_CAPTURE_EN: err_adr/err_exp/err_got hold the first
// mismatch of the run.
import dpram_bist_pkg::*;

module dpram_bist #(
   parameter int                DATA_W = 8,
   parameter int                ADDR_W = 3,
   parameter logic [DATA_W-1:0] SEED   = 8'h77,
   parameter int                RD_LAT = 1,
   parameter int                ERR_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_cnt,
   output logic              ce,
   output logic              we_a,
   output logic              we_b,
   output logic [DATA_W-1:0] din_a,
   output logic [ADDR_W-1:0] adr_a,
   output logic [DATA_W-1:0] din_b,
   output logic [ADDR_W-1:0] adr_b,
   input  logic [DATA_W-1:0] dout_a,
   input  logic [DATA_W-1:0] dout_b
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
   ,
   output logic [ADDR_W-1:0] err_adr,
   output logic [DATA_W-1:0] err_exp,
   output logic [DATA_W-1:0] err_got
`endif
);

   generate
      if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
         $error("dpram_bist: RD_LAT out of supported range");
      end
   endgenerate

   localparam logic [ADDR_W-1:0] ADR_MAX  = '1;
   localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
   localparam logic [1:0]        DRN_LAST = 2'(RD_LAT - 1);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        drn_cnt;
   logic [ERR_W-1:0]  err_nxt;
   logic              start_acc;
   logic [DATA_W-1:0] pat_cur;
   logic              issue_vld;
   logic              issue_sel_b;
   logic [DATA_W-1:0] issue_exp;
   logic              mismatch;
   logic [DATA_W-1:0] mis_exp;
   logic [DATA_W-1:0] mis_got;
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
   logic [ADDR_W-1:0] mis_adr;
`endif

   assign pat_cur = DATA_W'(pat(PAT_W'(SEED), PAT_W'(addr)));

   dpram_bist_chk #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .RD_LAT (RD_LAT)
   ) u_chk (
      .clk         (clk),
      .rst         (rst),
      .issue_vld   (issue_vld),
      .issue_sel_b (issue_sel_b),
      .issue_exp   (issue_exp),
      .dout_a      (dout_a),
      .dout_b      (dout_b),
      .mismatch    (mismatch),
      .mis_exp     (mis_exp),
      .mis_got     (mis_got)
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
      ,
      .issue_adr   (addr),
      .mis_adr     (mis_adr)
`endif
   );

   // Sequencer: next state plus every RAM-facing output. The RAM pins are a
   // pure function of state and address, so reset zeroes them at once.
   // The idle port always sits at address 0 with its write enable low.
   always_comb begin
      state_nxt   = state;
      start_acc   = 1'b0;
      busy        = 1'b0;
      ce          = 1'b0;
      we_a        = 1'b0;
      we_b        = 1'b0;
      din_a       = '0;
      din_b       = '0;
      adr_a       = '0;
      adr_b       = '0;
      issue_vld   = 1'b0;
      issue_sel_b = 1'b0;
      issue_exp   = '0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = WR1;
               start_acc = 1'b1;
            end
         end
         WR1: begin
            busy  = 1'b1;
            ce    = 1'b1;
            we_a  = 1'b1;
            adr_a = addr;
            din_a = pat_cur;
            if (addr == ADR_MAX) state_nxt = RD1;
         end
         RD1: begin
            busy        = 1'b1;
            ce          = 1'b1;
            adr_b       = addr;
            issue_vld   = 1'b1;
            issue_sel_b = 1'b1;
            issue_exp   = pat_cur;
            if (addr == ADR_MAX) state_nxt = DRN1;
         end
         DRN1: begin
            busy = 1'b1;
            if (drn_cnt == DRN_LAST) state_nxt = WR2;
         end
         WR2: begin
            busy  = 1'b1;
            ce    = 1'b1;
            we_b  = 1'b1;
            adr_b = addr;
            din_b = ~pat_cur;
            if (addr == ADR_MAX) state_nxt = RD2;
         end
         RD2: begin
            busy      = 1'b1;
            ce        = 1'b1;
            adr_a     = addr;
            issue_vld = 1'b1;
            issue_exp = ~pat_cur;
            if (addr == ADR_MAX) state_nxt = DRN2;
         end
         DRN2: begin
            busy = 1'b1;
            if (drn_cnt == DRN_LAST) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Error count for the next edge: cleared by an accepted start, otherwise
   // bumped per mismatch and pinned at all-ones.
   always_comb begin
      err_nxt = err_cnt;
      if (start_acc) begin
         err_nxt = '0;
      end else if (mismatch && (err_cnt != ERR_MAX)) begin
         err_nxt = err_cnt + 1'b1;
      end
   end

   // State, address/drain counters and result registers. pass looks at
   // err_nxt so a mismatch on the final drain cycle is still counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         addr    <= '0;
         drn_cnt <= '0;
         err_cnt <= '0;
         done    <= 1'b0;
         pass    <= 1'b0;
      end else begin
         state   <= state_nxt;
         err_cnt <= err_nxt;
         if (state == WR1 || state == RD1 || state == WR2 || state == RD2) begin
            addr <= addr + 1'b1;
         end else begin
            addr <= '0;
         end
         if ((state == DRN1 || state == DRN2) && (state_nxt == state)) begin
            drn_cnt <= drn_cnt + 1'b1;
         end else begin
            drn_cnt <= '0;
         end
         if (start_acc) begin
            done <= 1'b0;
            pass <= 1'b0;
         end else if (state == DRN2 && state_nxt == DONE) begin
            done <= 1'b1;
            pass <= (err_nxt == '0);
         end
      end
   end

`ifdef DPRAM_BIST_ERR_CAPTURE_EN
   // First mismatch of a run is the one seen while the count is still zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_adr <= '0;
         err_exp <= '0;
         err_got <= '0;
      end else if (start_acc) begin
         err_adr <= '0;
         err_exp <= '0;
         err_got <= '0;
      end else if (mismatch && (err_cnt == '0)) begin
         err_adr <= mis_adr;
         err_exp <= mis_exp;
         err_got <= mis_got;
      end
   end
`endif

endmodule

// File: tb/tb_dpram_bist.sv
// tb_dpram_bist
// Directed bench for dpram_bist. Three engines share clk/rst/start:
//  u0 default parameters with a 1-cycle RAM (optional bit-flip fault at
//     address 3 on port B reads), u1 RD_LAT=2 with a 2-cycle RAM,
//  u2 ERR_W=2 against a RAM whose read data is stuck at 8'h00.
// Covers DPRAM_BIST_ERR_CAPTURE_EN when that macro is defined.
`timescale 1ns/1ps

module tb_dpram_bist;

   logic clk;
   logic rst;
   logic start;
   logic fault_en;

   int tests;
   int fails;
   int b0, b1, b2;

   // u0 signals
   logic       busy0, done0, pass0, ce0, we_a0, we_b0;
   logic [7:0] err_cnt0, din_a0, din_b0, dout_a0, dout_b0;
   logic [2:0] adr_a0, adr_b0;
   logic [7:0] mem0 [8];
   // u1 signals
   logic       busy1, done1, pass1, ce1, we_a1, we_b1;
   logic [7:0] err_cnt1, din_a1, din_b1, dout_a1, dout_b1, da1_s1, db1_s1;
   logic [2:0] adr_a1, adr_b1;
   logic [7:0] mem1 [8];
   // u2 signals
   logic       busy2, done2, pass2, ce2, we_a2, we_b2;
   logic [1:0] err_cnt2;
   logic [7:0] din_a2, din_b2;
   logic [2:0] adr_a2, adr_b2;
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
   logic [2:0] err_adr0, err_adr1, err_adr2;
   logic [7:0] err_exp0, err_got0, err_exp1, err_got1, err_exp2, err_got2;
`endif

   dpram_bist u0 (
      .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
      .pass(pass0), .err_cnt(err_cnt0), .ce(ce0), .we_a(we_a0), .we_b(we_b0),
      .din_a(din_a0), .adr_a(adr_a0), .din_b(din_b0), .adr_b(adr_b0),
      .dout_a(dout_a0), .dout_b(dout_b0)
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
      , .err_adr(err_adr0), .err_exp(err_exp0), .err_got(err_got0)
`endif
   );

   dpram_bist #(.RD_LAT(2)) u1 (
      .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
      .pass(pass1), .err_cnt(err_cnt1), .ce(ce1), .we_a(we_a1), .we_b(we_b1),
      .din_a(din_a1), .adr_a(adr_a1), .din_b(din_b1), .adr_b(adr_b1),
      .dout_a(dout_a1), .dout_b(dout_b1)
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
      , .err_adr(err_adr1), .err_exp(err_exp1), .err_got(err_got1)
`endif
   );

   dpram_bist #(.ERR_W(2)) u2 (
      .clk(clk), .rst(rst), .start(start), .busy(busy2), .done(done2),
      .pass(pass2), .err_cnt(err_cnt2), .ce(ce2), .we_a(we_a2), .we_b(we_b2),
      .din_a(din_a2), .adr_a(adr_a2), .din_b(din_b2), .adr_b(adr_b2),
      .dout_a(8'h00), .dout_b(8'h00)
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
      , .err_adr(err_adr2), .err_exp(err_exp2), .err_got(err_got2)
`endif
   );

   // 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 1-cycle dual-port RAM for u0; fault_en flips bit 0 on port B reads of
   // address 3.
   always @(posedge clk) begin
      if (ce0) begin
         if (we_a0) mem0[adr_a0] <= din_a0;
         if (we_b0) mem0[adr_b0] <= din_b0;
         dout_a0 <= mem0[adr_a0];
         dout_b0 <= mem0[adr_b0] ^ ((fault_en && adr_b0 == 3'd3) ? 8'h01 : 8'h00);
      end
   end

   // 2-cycle dual-port RAM for u1.
   always @(posedge clk) begin
      if (ce1) begin
         if (we_a1) mem1[adr_a1] <= din_a1;
         if (we_b1) mem1[adr_b1] <= din_b1;
         da1_s1 <= mem1[adr_a1];
         db1_s1 <= mem1[adr_b1];
      end
      dout_a1 <= da1_s1;
      dout_b1 <= db1_s1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse start, check the first WR1 cycle of u0, then count busy cycles
   // of every engine until all are idle. restart_at re-pulses start at that
   // busy cycle (-1 = never).
   task automatic applyStimulus(input int restart_at);
      int cycle;
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("done_clr", 32'(done0), 32'd0);
      checkOutput("err_clr", 32'(err_cnt0), 32'd0);
      checkOutput("wr1_ce", 32'(ce0), 32'd1);
      checkOutput("wr1_we_a", 32'(we_a0), 32'd1);
      checkOutput("wr1_din_a", 32'(din_a0), 32'h77);
      checkOutput("wr1_we_b", 32'(we_b0), 32'd0);
      b0 = 0;
      b1 = 0;
      b2 = 0;
      cycle = 0;
      while ((busy0 || busy1 || busy2) && cycle < 200) begin
         if (busy0) b0++;
         if (busy1) b1++;
         if (busy2) b2++;
         start = (cycle == restart_at);
         tick();
         cycle++;
      end
      start = 1'b0;
      checkOutput("run_timeout", 32'(cycle < 200), 32'd1);
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      rst      = 1'b1;
      start    = 1'b0;
      fault_en = 1'b0;
      tick();
      tick();
      checkOutput("rst_busy", 32'(busy0), 32'd0);
      checkOutput("rst_done", 32'(done0), 32'd0);
      checkOutput("rst_pass", 32'(pass0), 32'd0);
      checkOutput("rst_err", 32'(err_cnt0), 32'd0);
      checkOutput("rst_ce", 32'(ce0), 32'd0);
      checkOutput("rst_we_a", 32'(we_a0), 32'd0);
      checkOutput("rst_adr_b", 32'(adr_b0), 32'd0);
      rst = 1'b0;
      tick();

      $display("[TB] clean run");
      applyStimulus(-1);
      checkOutput("clean_busy0", 32'(b0), 32'd34);
      checkOutput("clean_done0", 32'(done0), 32'd1);
      checkOutput("clean_pass0", 32'(pass0), 32'd1);
      checkOutput("clean_err0", 32'(err_cnt0), 32'd0);
      checkOutput("done_ce0", 32'(ce0), 32'd0);
      checkOutput("mem0_5", 32'(mem0[5]), 32'h8D);
      checkOutput("lat2_busy1", 32'(b1), 32'd36);
      checkOutput("lat2_pass1", 32'(pass1), 32'd1);
      checkOutput("lat2_err1", 32'(err_cnt1), 32'd0);
      checkOutput("mem1_5", 32'(mem1[5]), 32'h8D);
      checkOutput("stuck_busy2", 32'(b2), 32'd34);
      checkOutput("stuck_err2", 32'(err_cnt2), 32'd3);
      checkOutput("stuck_pass2", 32'(pass2), 32'd0);
      checkOutput("stuck_done2", 32'(done2), 32'd1);

      $display("[TB] fault run");
      fault_en = 1'b1;
      applyStimulus(-1);
      fault_en = 1'b0;
      checkOutput("fault_busy0", 32'(b0), 32'd34);
      checkOutput("fault_done0", 32'(done0), 32'd1);
      checkOutput("fault_pass0", 32'(pass0), 32'd0);
      checkOutput("fault_err0", 32'(err_cnt0), 32'd1);
      checkOutput("fault_pass1", 32'(pass1), 32'd1);
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
      checkOutput("cap_adr", 32'(err_adr0), 32'd3);
      checkOutput("cap_exp", 32'(err_exp0), 32'h74);
      checkOutput("cap_got", 32'(err_got0), 32'h75);
      checkOutput("cap_none1", 32'(err_adr1), 32'd0);
`endif

      $display("[TB] start while busy");
      applyStimulus(10);
      checkOutput("restart_busy0", 32'(b0), 32'd34);
      checkOutput("restart_pass0", 32'(pass0), 32'd1);
      checkOutput("restart_busy1", 32'(b1), 32'd36);
`ifdef DPRAM_BIST_ERR_CAPTURE_EN
      checkOutput("cap_clr", 32'(err_adr0), 32'd0);
`endif

      $display("[TB] reset during RD1");
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      checkOutput("rd1_adr_b", 32'(adr_b0), 32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("abort_busy0", 32'(busy0), 32'd0);
      checkOutput("abort_ce0", 32'(ce0), 32'd0);
      checkOutput("abort_err2", 32'(err_cnt2), 32'd0);
      checkOutput("abort_done0", 32'(done0), 32'd0);
      tick();
      applyStimulus(-1);
      checkOutput("after_busy0", 32'(b0), 32'd34);
      checkOutput("after_pass0", 32'(pass0), 32'd1);
      checkOutput("after_err0", 32'(err_cnt0), 32'd0);
      checkOutput("after_err2", 32'(err_cnt2), 32'd3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
